// File: rtl/tron_mem_pkg.sv
// Shared definitions for the memory port arbiter: owner-state encoding,
// default burst limit and a width helper for the burst counter.
package tron_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_VID = 2'd2
    } owner_e;

    localparam int VID_MAX_BURST_DEF = 4;

    // Bits needed to hold 0..max_burst inclusive.
    function automatic int cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/vid_burst_counter.sv
// Saturating, clearable count of consecutive video grants; at_limit flags
// that the video side has used up its burst allowance.
module vid_burst_counter
    import tron_mem_pkg::*;
#(
    parameter int MAX = VID_MAX_BURST_DEF,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_limit = (cnt_q == W'(MAX));
    assign cnt      = cnt_q;

    // Clear wins over increment; increment stops once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between a CPU port and a video
// read port; video has priority but is bounded by a burst limit.
module mem_port_arbiter
    import tron_mem_pkg::*;
#(
    parameter int VID_MAX_BURST = VID_MAX_BURST_DEF,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [DATA_W-1:0]               cpu_wdata,
    output logic                            cpu_grant,
    output logic                            cpu_valid,
    output logic [DATA_W-1:0]               cpu_rdata,
    input  logic                            vid_req,
    input  logic [ADDR_W-1:0]               vid_addr,
    output logic                            vid_grant,
    output logic                            vid_valid,
    output logic [DATA_W-1:0]               vid_rdata,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic                            mem_we,
    input  logic [DATA_W-1:0]               mem_rdata,
    output owner_e                          dbg_owner,
    output logic [cnt_w(VID_MAX_BURST)-1:0] dbg_burst_cnt
);

    // Handshake: a requester raises req with addr/data and holds them until
    // the cycle its grant is high; the grant is the single-cycle acceptance.
    // A granted read returns a one-cycle valid exactly one cycle later.

    owner_e owner_q;
    owner_e owner_d;
    logic   rd_pend_q;
    logic   rd_pend_d;
    logic   burst_at_limit;

    vid_burst_counter #(
        .MAX (VID_MAX_BURST),
        .W   (cnt_w(VID_MAX_BURST))
    ) u_burst (
        .clk      (clk),
        .rst      (reset),
        .inc      (vid_grant),
        .clr      (!vid_grant),
        .cnt      (dbg_burst_cnt),
        .at_limit (burst_at_limit)
    );

    // Grants are forced low while reset is held so nothing reaches the RAM.
    always_comb begin
        vid_grant = 1'b0;
        cpu_grant = 1'b0;
        if (!reset) begin
            if (vid_req && !(cpu_req && burst_at_limit)) begin
                vid_grant = 1'b1;
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = cpu_grant & cpu_we;
        mem_wdata = cpu_wdata;
        if (cpu_grant) begin
            mem_addr = cpu_addr;
        end else if (vid_grant) begin
            mem_addr = vid_addr;
        end
    end

    // Owner state doubles as the tag for the outstanding read.
    always_comb begin
        owner_d   = IDLE;
        rd_pend_d = 1'b0;
        if (cpu_grant) begin
            owner_d   = OWN_CPU;
            rd_pend_d = !cpu_we;
        end else if (vid_grant) begin
            owner_d   = OWN_VID;
            rd_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q   <= IDLE;
            rd_pend_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        cpu_valid = rd_pend_q && (owner_q == OWN_CPU);
        vid_valid = rd_pend_q && (owner_q == OWN_VID);
        cpu_rdata = cpu_valid ? mem_rdata : '0;
        vid_rdata = vid_valid ? mem_rdata : '0;
    end

    assign dbg_owner = owner_q;

endmodule
